// File: rtl/mem_align_split_if.sv
// Bus bundle for mem_align_split: upstream request side plus downstream memory side.
// The slave modport is the aligner's view; master is the environment's view.
interface mem_align_split_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              up_read;
    logic              up_write;
    logic [ADDR_W-1:0] up_addr;
    logic [1:0]        up_size;
    logic              up_unsigned;
    logic [DATA_W-1:0] up_wdata;
    logic [DATA_W-1:0] up_rdata;
    logic              up_resp;
    logic              up_fault;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BYTES-1:0]  mem_byte_enable;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  up_read, up_write, up_addr, up_size,
        input  up_unsigned, up_wdata,
        output up_rdata, up_resp, up_fault,
        output mem_read, mem_write, mem_addr,
        output mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp
    );

    modport master (
        output up_read, up_write, up_addr, up_size,
        output up_unsigned, up_wdata,
        input  up_rdata, up_resp, up_fault,
        input  mem_read, mem_write, mem_addr,
        input  mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_align_split.sv
// Misaligned load/store splitter onto an aligned memory bus.
// MEM_ALIGN_SPLIT_CROSS_EN enables two-beat line-crossing accesses; else they fault.
module mem_align_split #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    mem_align_split_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);
`ifdef MEM_ALIGN_SPLIT_CROSS_EN
    localparam bit CROSS_EN = 1'b1;
`else
    localparam bit CROSS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wr;
    logic [DATA_W-1:0]   r_up_rdata;
    logic                r_up_resp;
    logic                r_up_fault;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [BYTES-1:0]    r_mem_be;
`ifdef MEM_ALIGN_SPLIT_CROSS_EN
    logic [DATA_W-1:0]   r_beat1;
`endif

    logic                w_idle;
    logic [ADDR_W-1:0]   w_addr;
    logic [1:0]          w_size;
    logic [DATA_W-1:0]   w_wdata;
    logic [OFS_W-1:0]    w_ofs;
    logic [3:0]          w_n;
    logic                w_cross;
    logic                w_illegal;
    logic [ADDR_W-1:0]   w_aligned;
    logic [2*BYTES-1:0]  w_nmask;
    logic [2*BYTES-1:0]  w_lanes;
    logic [2*DATA_W-1:0] w_data2;
    logic [2*DATA_W-1:0] w_pair;
    logic [2*DATA_W-1:0] w_shift;
    logic [DATA_W-1:0]   w_raw;
    logic [DATA_W-1:0]   w_keep;
    logic                w_sign;
    logic                w_ext;
    logic [DATA_W-1:0]   w_load;

    // In IDLE the geometry comes straight from the request so the first
    // beat can be launched on the accepting edge; later from the registers.
    assign w_idle  = (r_state == IDLE);
    assign w_addr  = w_idle ? bus.up_addr  : r_addr;
    assign w_size  = w_idle ? bus.up_size  : r_size;
    assign w_wdata = w_idle ? bus.up_wdata : r_wdata;

    assign w_ofs     = w_addr[OFS_W-1:0];
    assign w_n       = 4'b0001 << w_size;
    assign w_cross   = (5'(w_ofs) + 5'(w_n)) > 5'(BYTES);
    assign w_illegal = w_n > 4'(BYTES);
    assign w_aligned = {w_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

    always_comb begin
        w_nmask = '0;
        for (int b = 0; b < 2 * BYTES; b++) begin
            w_nmask[b] = 5'(b) < 5'(w_n);
        end
    end

    assign w_lanes = w_nmask << w_ofs;
    assign w_data2 = {{DATA_W{1'b0}}, w_wdata} << {w_ofs, 3'b000};

`ifdef MEM_ALIGN_SPLIT_CROSS_EN
    assign w_pair = (r_state == ACC2) ? {bus.mem_rdata, r_beat1}
                                      : {{DATA_W{1'b0}}, bus.mem_rdata};
`else
    assign w_pair = {{DATA_W{1'b0}}, bus.mem_rdata};
    logic w_unused;
    assign w_unused = ^{w_data2[2*DATA_W-1:DATA_W],
                        w_lanes[2*BYTES-1:BYTES]};
`endif

    assign w_shift = w_pair >> {w_ofs, 3'b000};
    assign w_raw   = w_shift[DATA_W-1:0];

    always_comb begin
        w_keep = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_keep[8*b +: 8] = {8{w_nmask[b]}};
        end
    end

    always_comb begin
        w_sign = 1'b0;
        case (w_size)
            2'd0:    w_sign = w_raw[7];
            2'd1:    w_sign = w_raw[15];
            2'd2:    w_sign = w_raw[31];
            default: w_sign = w_raw[DATA_W-1];
        endcase
    end

    assign w_ext  = ~r_uns & w_sign;
    assign w_load = (w_raw & w_keep) | ({DATA_W{w_ext}} & ~w_keep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_wdata     <= '0;
            r_wr        <= 1'b0;
            r_up_rdata  <= '0;
            r_up_resp   <= 1'b0;
            r_up_fault  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
`ifdef MEM_ALIGN_SPLIT_CROSS_EN
            r_beat1     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.up_read || bus.up_write) begin
                        r_addr  <= bus.up_addr;
                        r_size  <= bus.up_size;
                        r_uns   <= bus.up_unsigned;
                        r_wdata <= bus.up_wdata;
                        r_wr    <= bus.up_write;
                        if (w_illegal || (w_cross && !CROSS_EN)) begin
                            r_state    <= RESP;
                            r_up_resp  <= 1'b1;
                            r_up_fault <= 1'b1;
                            r_up_rdata <= '0;
                        end else begin
                            r_state     <= ACC1;
                            r_mem_read  <= ~bus.up_write;
                            r_mem_write <= bus.up_write;
                            r_mem_addr  <= w_aligned;
                            r_mem_wdata <= bus.up_write ?
                                w_data2[DATA_W-1:0] : '0;
                            r_mem_be    <= bus.up_write ?
                                w_lanes[BYTES-1:0] : '0;
                        end
                    end
                end
                ACC1: begin
                    if (bus.mem_resp) begin
                        if (w_cross && CROSS_EN) begin
`ifdef MEM_ALIGN_SPLIT_CROSS_EN
                            r_beat1     <= bus.mem_rdata;
                            r_state     <= ACC2;
                            r_mem_addr  <= w_aligned + ADDR_W'(BYTES);
                            r_mem_wdata <= r_wr ?
                                w_data2[2*DATA_W-1:DATA_W] : '0;
                            r_mem_be    <= r_wr ?
                                w_lanes[2*BYTES-1:BYTES] : '0;
`endif
                        end else begin
                            r_state     <= RESP;
                            r_mem_read  <= 1'b0;
                            r_mem_write <= 1'b0;
                            r_mem_wdata <= '0;
                            r_mem_be    <= '0;
                            r_up_resp   <= 1'b1;
                            r_up_fault  <= 1'b0;
                            r_up_rdata  <= r_wr ? '0 : w_load;
                        end
                    end
                end
`ifdef MEM_ALIGN_SPLIT_CROSS_EN
                ACC2: begin
                    if (bus.mem_resp) begin
                        r_state     <= RESP;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '0;
                        r_up_resp   <= 1'b1;
                        r_up_fault  <= 1'b0;
                        r_up_rdata  <= r_wr ? '0 : w_load;
                    end
                end
`endif
                RESP: begin
                    r_up_resp  <= 1'b0;
                    r_up_fault <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.up_rdata        = r_up_rdata;
    assign bus.up_resp         = r_up_resp;
    assign bus.up_fault        = r_up_fault;
    assign bus.mem_read        = r_mem_read;
    assign bus.mem_write       = r_mem_write;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_byte_enable = r_mem_be;
endmodule

// File: tb/tb_mem_align_split.sv
// Directed bench for mem_align_split (DATA_W=32) with a stepped memory responder.
// Crossing expectations follow MEM_ALIGN_SPLIT_CROSS_EN as compiled.
module tb_mem_align_split;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_align_split_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_align_split #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] lg_addr [4];
    logic [31:0] lg_wd [4];
    logic [3:0]  lg_be [4];
    logic        lg_wr [4];
    int          nb;
    int          lat;
    logic [31:0] rd;
    logic        flt;
    int          seen;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request and act as memory; waits = stall cycles per beat.
    task automatic xfer(input bit rs, input bit ws, input logic [31:0] addr,
                        input logic [1:0] size, input bit uns,
                        input logic [31:0] wd, input logic [31:0] b0,
                        input logic [31:0] b1, input int waits);
        int  wc;
        bit  done;
        wc = 0;
        done = 1'b0;
        nb = 0;
        lat = 0;
        rd = '0;
        flt = 1'b0;
        bus.up_read = rs;
        bus.up_write = ws;
        bus.up_addr = addr;
        bus.up_size = size;
        bus.up_unsigned = uns;
        bus.up_wdata = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            lat++;
            chk("excl", {63'd0, bus.mem_read & bus.mem_write}, 64'd0);
            if (bus.up_resp) begin
                rd = bus.up_rdata;
                flt = bus.up_fault;
                done = 1'b1;
                bus.mem_resp = 1'b0;
            end else if (bus.mem_read || bus.mem_write) begin
                if (wc < waits) begin
                    wc++;
                    bus.mem_resp = 1'b0;
                end else begin
                    wc = 0;
                    if (nb < 4) begin
                        lg_addr[nb] = bus.mem_addr;
                        lg_wd[nb] = bus.mem_wdata;
                        lg_be[nb] = bus.mem_byte_enable;
                        lg_wr[nb] = bus.mem_write;
                    end
                    bus.mem_resp = 1'b1;
                    bus.mem_rdata = (nb == 0) ? b0 : b1;
                    nb++;
                end
            end else begin
                bus.mem_resp = 1'b0;
            end
        end
        bus.up_read = 1'b0;
        bus.up_write = 1'b0;
        bus.mem_resp = 1'b0;
        if (!done) chk("timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        bus.up_read = 1'b0;
        bus.up_write = 1'b0;
        bus.up_addr = '0;
        bus.up_size = '0;
        bus.up_unsigned = 1'b0;
        bus.up_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_resp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_strb", {60'd0, bus.mem_read, bus.mem_write,
                         bus.up_resp, bus.up_fault}, 64'd0);
        chk("rst_be", {60'd0, bus.mem_byte_enable}, 64'd0);
        chk("rst_addr", {32'd0, bus.mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, bus.mem_wdata}, 64'd0);
        chk("rst_rdata", {32'd0, bus.up_rdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // word load, aligned
        xfer(1, 0, 32'h100, 2'd2, 0, 0, 32'hDEADBEEF, 0, 0);
        chk("lw_data", {32'd0, rd}, 64'hDEADBEEF);
        chk("lw_lat", 64'(lat), 64'd2);
        chk("lw_nb", 64'(nb), 64'd1);
        chk("lw_addr", {32'd0, lg_addr[0]}, 64'h100);
        chk("lw_be", {60'd0, lg_be[0]}, 64'd0);
        chk("lw_flt", {63'd0, flt}, 64'd0);

        // byte loads, signed and unsigned
        xfer(1, 0, 32'h103, 2'd0, 0, 0, 32'h80000000, 0, 0);
        chk("lb_s", {32'd0, rd}, 64'hFFFFFF80);
        xfer(1, 0, 32'h103, 2'd0, 1, 0, 32'h80000000, 0, 0);
        chk("lb_u", {32'd0, rd}, 64'h00000080);

        // signed half load at odd offset, non-crossing
        xfer(1, 0, 32'h101, 2'd1, 0, 0, 32'h00F00000, 0, 0);
        chk("lh_s", {32'd0, rd}, 64'hFFFFF000);
        chk("lh_nb", 64'(nb), 64'd1);

        // half store
        xfer(0, 1, 32'h102, 2'd1, 0, 32'h1234ABCD, 0, 0, 0);
        chk("sh_nb", 64'(nb), 64'd1);
        chk("sh_addr", {32'd0, lg_addr[0]}, 64'h100);
        chk("sh_wd", {32'd0, lg_wd[0]}, 64'hABCD0000);
        chk("sh_be", {60'd0, lg_be[0]}, 64'b1100);
        chk("sh_lat", 64'(lat), 64'd2);

        // read and write together: write wins
        xfer(1, 1, 32'h101, 2'd0, 0, 32'h000000AA, 0, 0, 0);
        chk("ww_wr", {63'd0, lg_wr[0]}, 64'd1);
        chk("ww_be", {60'd0, lg_be[0]}, 64'b0010);
        chk("ww_wd", {32'd0, lg_wd[0]}, 64'h0000AA00);

        // illegal dword on a 32-bit bus
        xfer(1, 0, 32'h100, 2'd3, 0, 0, 32'h12345678, 0, 0);
        chk("ill_flt", {63'd0, flt}, 64'd1);
        chk("ill_data", {32'd0, rd}, 64'd0);
        chk("ill_nb", 64'(nb), 64'd0);
        chk("ill_lat", 64'(lat), 64'd1);

        // crossing word store
        xfer(0, 1, 32'h0FE, 2'd2, 0, 32'h11223344, 0, 0, 0);
`ifdef MEM_ALIGN_SPLIT_CROSS_EN
        chk("sx_nb", 64'(nb), 64'd2);
        chk("sx_a0", {32'd0, lg_addr[0]}, 64'h0FC);
        chk("sx_be0", {60'd0, lg_be[0]}, 64'b1100);
        chk("sx_wd0", {32'd0, lg_wd[0]}, 64'h33440000);
        chk("sx_a1", {32'd0, lg_addr[1]}, 64'h100);
        chk("sx_be1", {60'd0, lg_be[1]}, 64'b0011);
        chk("sx_wd1", {32'd0, lg_wd[1]}, 64'h00001122);
        chk("sx_lat", 64'(lat), 64'd3);
        chk("sx_flt", {63'd0, flt}, 64'd0);
`else
        chk("sx_nb", 64'(nb), 64'd0);
        chk("sx_flt", {63'd0, flt}, 64'd1);
        chk("sx_lat", 64'(lat), 64'd1);
`endif

        // crossing word load with two stall cycles per beat
        xfer(1, 0, 32'h103, 2'd2, 0, 0, 32'h44000000, 32'h00332211, 2);
`ifdef MEM_ALIGN_SPLIT_CROSS_EN
        chk("lx_data", {32'd0, rd}, 64'h33221144);
        chk("lx_lat", 64'(lat), 64'd7);
        chk("lx_a1", {32'd0, lg_addr[1]}, 64'h104);
        chk("lx_be1", {60'd0, lg_be[1]}, 64'd0);
`else
        chk("lx_flt", {63'd0, flt}, 64'd1);
        chk("lx_data", {32'd0, rd}, 64'd0);
        chk("lx_nb", 64'(nb), 64'd0);
`endif

        // crossing load wrapping past the top of the address space
        xfer(1, 0, 32'hFFFFFFFE, 2'd2, 1, 0, 32'h22110000, 32'h00004433, 0);
`ifdef MEM_ALIGN_SPLIT_CROSS_EN
        chk("wrap_a0", {32'd0, lg_addr[0]}, 64'hFFFFFFFC);
        chk("wrap_a1", {32'd0, lg_addr[1]}, 64'h0);
        chk("wrap_data", {32'd0, rd}, 64'h44332211);
`else
        chk("wrap_flt", {63'd0, flt}, 64'd1);
        chk("wrap_nb", 64'(nb), 64'd0);
`endif

        // reset while a beat is outstanding
        bus.up_read = 1'b1;
        bus.up_write = 1'b0;
        bus.up_addr = 32'h100;
        bus.up_size = 2'd2;
        @(negedge clk);
        chk("mid_rd_on", {63'd0, bus.mem_read}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("mid_rd_drop", {63'd0, bus.mem_read}, 64'd0);
        bus.up_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_resp = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            bus.mem_resp = 1'b0;
            if (bus.up_resp) seen++;
        end
        chk("mid_noresp", 64'(seen), 64'd0);
        chk("mid_idle", {62'd0, bus.mem_read, bus.mem_write}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
